// File: rtl/emu_host_sequencer.sv
// Host-side master for the emulation wrapper: write stimulus, load, pulse clk_dut, get, read back.
// Latency: NUM_STIM + 1 + ncyc*(CLK_HI+CLK_LO) + 1 + (NUM_OUT+1) cycles from accept to resp_valid.
// Backpressure: cmd_ready only in IDLE; resp_valid holds with stable resp_vect until resp_ready.
module emu_host_sequencer #(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 2,
  parameter int ADDR_W   = 3,
  parameter int CLK_HI   = 2,
  parameter int CLK_LO   = 2
) (
  input  logic                  clk_emu,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8*NUM_STIM-1:0] cmd_stim,
  input  logic [7:0]            cmd_ncyc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [8*NUM_OUT-1:0]  resp_vect,
  output logic [7:0]            Din_emu,
  input  logic [7:0]            Dout_emu,
  output logic [ADDR_W-1:0]     Addr_emu,
  output logic                  load_emu,
  output logic                  get_emu,
  output logic                  clk_dut,
  output logic                  busy
);

  // idx needs one extra bit so it can count to NUM_OUT when NUM_OUT == 2**ADDR_W
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PH_MAX = (CLK_HI > CLK_LO) ? CLK_HI : CLK_LO;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_LOAD,
    S_PULSE_HI,
    S_PULSE_LO,
    S_GET,
    S_READ,
    S_RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      idx;
  logic [PH_W-1:0]       ph;
  logic [7:0]            ncyc;
  logic [8*NUM_STIM-1:0] stim_copy;

  // State register
  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and strobe/address outputs
  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    load_emu   = 1'b0;
    get_emu    = 1'b0;
    busy       = 1'b1;
    Addr_emu   = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        Addr_emu = idx[ADDR_W-1:0];
        if (idx == CNT_W'(NUM_STIM - 1)) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        load_emu  = 1'b1;
        state_nxt = (ncyc != 8'd0) ? S_PULSE_HI : S_GET;
      end
      S_PULSE_HI: begin
        if (ph == PH_W'(CLK_HI - 1)) state_nxt = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        if (ph == PH_W'(CLK_LO - 1)) state_nxt = (ncyc == 8'd1) ? S_GET : S_PULSE_HI;
      end
      S_GET: begin
        get_emu   = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        // last cycle only drains the wrapper's output register, so the address is held in range
        Addr_emu = (idx < CNT_W'(NUM_OUT)) ? idx[ADDR_W-1:0] : ADDR_W'(NUM_OUT - 1);
        if (idx == CNT_W'(NUM_OUT)) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Din always mirrors the stimulus byte at the current address so the wrapper's
  // free-running rewrite of stimIn never corrupts it; out-of-range addresses get 0
  always_comb begin
    Din_emu = '0;
    for (int i = 0; i < NUM_STIM; i++) begin
      if (Addr_emu == ADDR_W'(i)) Din_emu = stim_copy[8*i +: 8];
    end
  end

  // Counters, command latch, readback capture and the registered DUT clock
  always_ff @(posedge clk_emu or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      ph        <= '0;
      ncyc      <= '0;
      stim_copy <= '0;
      resp_vect <= '0;
      clk_dut   <= 1'b0;
    end else begin
      clk_dut <= (state_nxt == S_PULSE_HI);
      if (state == S_IDLE && cmd_valid) begin
        stim_copy <= cmd_stim;
        ncyc      <= cmd_ncyc;
      end
      if (state == S_PULSE_LO && state_nxt != S_PULSE_LO) begin
        ncyc <= ncyc - 8'd1;
      end
      if (state_nxt != state) begin
        idx <= '0;
        ph  <= '0;
      end else begin
        if (state == S_WRITE || state == S_READ) idx <= idx + 1'b1;
        if (state == S_PULSE_HI || state == S_PULSE_LO) ph <= ph + 1'b1;
      end
      // Dout_emu lags Addr_emu by one cycle: READ cycle j+1 holds byte j
      if (state == S_READ) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (idx == CNT_W'(i + 1)) resp_vect[8*i +: 8] <= Dout_emu;
        end
      end
    end
  end

endmodule

// File: tb/tb_emu_host_sequencer.sv
module tb_emu_host_sequencer;
  localparam int NUM_STIM = 1;
  localparam int NUM_OUT  = 2;
  localparam int ADDR_W   = 3;
  localparam int CLK_HI   = 2;
  localparam int CLK_LO   = 2;
  localparam int BUDGET   = 3000;

  logic              clk_emu = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_stim;
  logic [7:0]        cmd_ncyc;
  logic              resp_valid;
  logic              resp_ready;
  logic [15:0]       resp_vect;
  logic [7:0]        Din_emu;
  logic [7:0]        Dout_emu;
  logic [ADDR_W-1:0] Addr_emu;
  logic              load_emu;
  logic              get_emu;
  logic              clk_dut;
  logic              busy;

  emu_host_sequencer #(
    .NUM_STIM(NUM_STIM), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .CLK_HI(CLK_HI), .CLK_LO(CLK_LO)
  ) dut (
    .clk_emu(clk_emu), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_stim(cmd_stim), .cmd_ncyc(cmd_ncyc), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_vect(resp_vect), .Din_emu(Din_emu), .Dout_emu(Dout_emu), .Addr_emu(Addr_emu),
    .load_emu(load_emu), .get_emu(get_emu), .clk_dut(clk_dut), .busy(busy)
  );

  always #5 clk_emu = ~clk_emu;

  // Behavioural wrapper + DUT: stimIn rewritten when load/get low, acc += in+1 per clk_dut
  // rising edge, edge counter cleared by load, outputs captured on get, Dout registered.
  logic [7:0] stim_reg, app_in, acc, dut_edges, vout0, vout1;
  logic       clk_d, fixed_mode;
  always @(posedge clk_emu) begin
    clk_d <= clk_dut;
    if (clk_dut && !clk_d) begin
      acc       <= acc + app_in + 8'd1;
      dut_edges <= dut_edges + 8'd1;
    end
    if (load_emu) begin
      app_in    <= stim_reg;
      dut_edges <= 8'd0;
    end else if (!get_emu && Addr_emu == 3'd0) begin
      stim_reg <= Din_emu;
    end
    if (get_emu) begin
      vout0 <= fixed_mode ? 8'hA5 : acc;
      vout1 <= fixed_mode ? 8'h3C : dut_edges;
    end
    Dout_emu <= (Addr_emu == 3'd0) ? vout0 : (Addr_emu == 3'd1) ? vout1 : 8'h00;
  end

  always @(posedge clk_emu) begin
    if (reset_n) assert (!(load_emu && get_emu)) else $error("FAIL load_get_overlap both high");
  end

  int n_cmp = 0;
  int n_bad = 0;
  int r_lat, r_edges, r_loads, r_gets, r_gap, r_viol, r_wait;
  logic [15:0] r_resp;
  logic        r_idle_ready;
  logic [7:0]  ref_acc;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one command from a negedge; ends at the negedge after the response handshake.
  task automatic run_txn(input logic [7:0] s, input logic [7:0] n, input int hold,
                         input logic nv, input logic [7:0] ns, input logic [7:0] nn);
    int k, run, t_load, t_get;
    logic prev;
    logic [15:0] v0;
    cmd_stim = s; cmd_ncyc = n; cmd_valid = 1'b1;
    r_wait = 0;
    while (!cmd_ready && r_wait < BUDGET) begin @(negedge clk_emu); r_wait++; end
    @(posedge clk_emu);
    @(negedge clk_emu);
    cmd_valid = 1'b0;
    k = 1; run = 0; prev = 1'b0; t_load = 0; t_get = 0;
    r_edges = 0; r_loads = 0; r_gets = 0; r_viol = 0;
    while (!resp_valid && k < BUDGET) begin
      if (load_emu) begin r_loads++; t_load = k; end
      if (get_emu) begin r_gets++; t_get = k; end
      if (load_emu && get_emu) r_viol++;
      if (cmd_ready || !busy) r_viol++;
      if (Addr_emu >= 3'(NUM_OUT)) r_viol++;
      if (Addr_emu == 3'd0 && Din_emu !== s) r_viol++;
      if (Addr_emu != 3'd0 && Din_emu !== 8'h00) r_viol++;
      if (clk_dut && !prev) r_edges++;
      if (clk_dut) run++;
      else begin
        if (prev && run != CLK_HI) r_viol++;
        run = 0;
      end
      prev = clk_dut;
      @(negedge clk_emu);
      k++;
    end
    r_lat = k;
    r_gap = t_get - t_load;
    v0 = resp_vect;
    cmd_valid = nv; cmd_stim = ns; cmd_ncyc = nn;
    for (int h = 0; h < hold; h++) begin
      if (resp_vect !== v0 || !resp_valid || cmd_ready || clk_dut) r_viol++;
      @(negedge clk_emu);
    end
    r_resp = resp_vect;
    resp_ready = 1'b1;
    @(posedge clk_emu);
    @(negedge clk_emu);
    resp_ready = 1'b0;
    r_idle_ready = cmd_ready;
  endtask

  task automatic check_txn(input string tag, input logic [7:0] s, input logic [7:0] n,
                           input logic [15:0] exp_resp);
    int exp_lat;
    exp_lat = NUM_STIM + 1 + int'(n) * (CLK_HI + CLK_LO) + 1 + (NUM_OUT + 1) + 1;
    chk({tag, "_lat"}, r_lat, exp_lat);
    chk({tag, "_resp"}, int'(r_resp), int'(exp_resp));
    chk({tag, "_edges"}, r_edges, int'(n));
    chk({tag, "_loads"}, r_loads, 1);
    chk({tag, "_gets"}, r_gets, 1);
    chk({tag, "_load_to_get"}, r_gap, 1 + int'(n) * (CLK_HI + CLK_LO));
    chk({tag, "_viol"}, r_viol, 0);
    chk({tag, "_stimin"}, int'(stim_reg), int'(s));
    chk({tag, "_idle_ready"}, int'(r_idle_ready), 1);
  endtask

  function automatic logic [15:0] predict(input logic [7:0] s, input logic [7:0] n);
    int t;
    logic [7:0] a;
    t = int'(n) * (int'(s) + 1);
    a = ref_acc + t[7:0];
    return {n, a};
  endfunction

  typedef struct {
    logic [7:0]  stim;
    logic [7:0]  ncyc;
    logic [15:0] resp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [7:0] s, n;
    int k;
    tbl[0] = '{8'h05, 8'd1, 16'h0106};
    tbl[1] = '{8'h10, 8'd0, 16'h0006};
    tbl[2] = '{8'h02, 8'd3, 16'h030F};
    tbl[3] = '{8'hFF, 8'd2, 16'h020F};
    tbl[4] = '{8'h7F, 8'd5, 16'h058F};
    acc = 8'h00; app_in = 8'h00; dut_edges = 8'h00; fixed_mode = 1'b0;
    vout0 = 8'h00; vout1 = 8'h00; ref_acc = 8'h00;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_stim = 8'h00; cmd_ncyc = 8'h00; resp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_outs", int'({resp_valid, load_emu, get_emu, clk_dut, busy}), 0);
    chk("rst_addr_din", int'({Addr_emu, Din_emu}), 0);
    chk("rst_resp_vect", int'(resp_vect), 0);
    repeat (3) @(negedge clk_emu);
    reset_n = 1'b1;
    @(negedge clk_emu);

    // table-driven transactions, model accumulator starts at 0
    for (int i = 0; i < 5; i++) begin
      run_txn(tbl[i].stim, tbl[i].ncyc, 0, 1'b0, 8'h00, 8'h00);
      check_txn($sformatf("tbl%0d", i), tbl[i].stim, tbl[i].ncyc, tbl[i].resp);
      ref_acc = predict(tbl[i].stim, tbl[i].ncyc)[7:0];
    end

    // fixed wrapper outputs: readback byte ordering
    fixed_mode = 1'b1;
    run_txn(8'h05, 8'd1, 0, 1'b0, 8'h00, 8'h00);
    check_txn("readback", 8'h05, 8'd1, 16'h3CA5);
    ref_acc = predict(8'h05, 8'd1)[7:0];
    fixed_mode = 1'b0;

    // backpressure with a pending command, then back-to-back acceptance
    run_txn(8'h33, 8'd2, 20, 1'b1, 8'hC4, 8'd1);
    check_txn("bp_first", 8'h33, 8'd2, predict(8'h33, 8'd2));
    ref_acc = predict(8'h33, 8'd2)[7:0];
    run_txn(8'hC4, 8'd1, 0, 1'b0, 8'h00, 8'h00);
    chk("b2b_accept_wait", r_wait, 0);
    check_txn("b2b_second", 8'hC4, 8'd1, predict(8'hC4, 8'd1));
    ref_acc = predict(8'hC4, 8'd1)[7:0];

    // maximum pulse count
    run_txn(8'h03, 8'd255, 1, 1'b0, 8'h00, 8'h00);
    check_txn("ncyc255", 8'h03, 8'd255, predict(8'h03, 8'd255));
    ref_acc = predict(8'h03, 8'd255)[7:0];

    // randomized commands against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      s = 8'($urandom);
      n = 8'($urandom_range(0, 6));
      run_txn(s, n, int'($urandom_range(0, 3)), 1'b0, 8'h00, 8'h00);
      check_txn($sformatf("rnd%0d", i), s, n, predict(s, n));
      ref_acc = predict(s, n)[7:0];
    end

    // reset while clk_dut is high, then a fresh command
    cmd_stim = 8'h5A; cmd_ncyc = 8'd3; cmd_valid = 1'b1;
    @(posedge clk_emu);
    @(negedge clk_emu);
    cmd_valid = 1'b0;
    k = 0;
    while (!clk_dut && k < 100) begin @(negedge clk_emu); k++; end
    chk("midrst_reached_hi", int'(clk_dut), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_clk_dut", int'(clk_dut), 0);
    chk("midrst_strobes", int'({load_emu, get_emu, resp_valid, busy}), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk_emu);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_emu);
    ref_acc = acc;
    run_txn(8'h21, 8'd2, 2, 1'b0, 8'h00, 8'h00);
    check_txn("after_rst", 8'h21, 8'd2, predict(8'h21, 8'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
